// File: rtl/exibe_sequencia_pkg.sv
// Shared definitions for the memory game: data widths and the presenter FSM
// state encoding (codes are also shown on the hex display).
package exibe_sequencia_pkg;

    localparam int LED_W  = 4;
    localparam int ADDR_W = 4;

    typedef enum logic [3:0] {
        OCIOSO  = 4'd0,
        LEITURA = 4'd1,
        ACENDE  = 4'd2,
        APAGA   = 4'd3,
        PROXIMO = 4'd4,
        FIM     = 4'd5
    } estado_t;

    function automatic logic estado_ativo(input estado_t e);
        return (e != OCIOSO);
    endfunction

endpackage

// File: rtl/exibe_sequencia_contador.sv
// Generic up-counter with synchronous clear, count enable and a terminal-count
// flag against a selectable limit; also used by the game's timeout logic.
module contador_temporizador #(
    parameter int W = 13
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_clear,
    input  logic         i_enable,
    input  logic [W-1:0] i_limite,
    output logic         o_fim
);

    logic [W-1:0] r_count;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_enable) begin
            r_count <= r_count + 1'b1;
        end
    end

    // Flag is independent of i_enable so the caller can use it without a comb loop.
    assign o_fim = (r_count == i_limite);

endmodule

// File: rtl/exibe_sequencia.sv
// Plays the stored colour sequence (addresses 0..rodada) on the LEDs: each
// value lit for ON_CYCLES, then blank for OFF_CYCLES; pulses pronto at the end.
module exibe_sequencia
    import exibe_sequencia_pkg::*;
#(
    parameter int ON_CYCLES  = 5000,
    parameter int OFF_CYCLES = 2000,
    parameter int CNT_W      = 13
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              iniciar,
    input  logic [ADDR_W-1:0] rodada,
    input  logic [LED_W-1:0]  dado,
    output logic [ADDR_W-1:0] endereco,
    output logic [LED_W-1:0]  leds,
    output logic              ocupado,
    output logic              pronto,
    output logic [3:0]        db_estado
);

    localparam logic [CNT_W-1:0] ON_TERM  = CNT_W'(ON_CYCLES - 1);
    localparam logic [CNT_W-1:0] OFF_TERM = CNT_W'(OFF_CYCLES - 1);

    estado_t           r_estado;
    logic [ADDR_W-1:0] r_endereco;
    logic [LED_W-1:0]  r_leds;
    logic [ADDR_W-1:0] r_rodada;

    estado_t           w_prox_estado;
    logic [ADDR_W-1:0] w_prox_endereco;
    logic [LED_W-1:0]  w_prox_leds;
    logic [ADDR_W-1:0] w_prox_rodada;
    logic              w_limpa;
    logic              w_conta;
    logic              w_fim;
    logic [CNT_W-1:0]  w_limite;

    assign w_limite = (r_estado == APAGA) ? OFF_TERM : ON_TERM;

    contador_temporizador #(
        .W (CNT_W)
    ) u_timer (
        .i_clk    (clock),
        .i_rst    (reset),
        .i_clear  (w_limpa),
        .i_enable (w_conta),
        .i_limite (w_limite),
        .o_fim    (w_fim)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_estado   <= OCIOSO;
            r_endereco <= '0;
            r_leds     <= '0;
            r_rodada   <= '0;
        end else begin
            r_estado   <= w_prox_estado;
            r_endereco <= w_prox_endereco;
            r_leds     <= w_prox_leds;
            r_rodada   <= w_prox_rodada;
        end
    end

    always_comb begin
        w_prox_estado   = r_estado;
        w_prox_endereco = r_endereco;
        w_prox_leds     = r_leds;
        w_prox_rodada   = r_rodada;
        w_limpa         = 1'b0;
        w_conta         = 1'b0;

        case (r_estado)
            OCIOSO: begin
                w_prox_leds = '0;
                if (iniciar) begin
                    w_prox_rodada   = rodada;
                    w_prox_endereco = '0;
                    w_prox_estado   = LEITURA;
                end
            end
            LEITURA: begin
                w_prox_leds   = dado;
                w_limpa       = 1'b1;
                w_prox_estado = ACENDE;
            end
            ACENDE: begin
                w_conta = 1'b1;
                if (w_fim) begin
                    w_prox_leds   = '0;
                    w_limpa       = 1'b1;
                    w_prox_estado = APAGA;
                end
            end
            APAGA: begin
                w_conta = 1'b1;
                if (w_fim) begin
                    w_prox_estado = PROXIMO;
                end
            end
            PROXIMO: begin
                // Compare before incrementing so rodada=15 ends without wrapping.
                if (r_endereco == r_rodada) begin
                    w_prox_estado = FIM;
                end else begin
                    w_prox_endereco = r_endereco + 1'b1;
                    w_prox_estado   = LEITURA;
                end
            end
            FIM: begin
                w_prox_estado = OCIOSO;
            end
            default: begin
                w_prox_leds   = '0;
                w_prox_estado = OCIOSO;
            end
        endcase
    end

    assign endereco  = r_endereco;
    assign leds      = r_leds;
    assign ocupado   = estado_ativo(r_estado);
    assign pronto    = (r_estado == FIM);
    assign db_estado = r_estado;

endmodule

// File: tb/tb_exibe_sequencia.sv
// Directed bench for exibe_sequencia with ON_CYCLES=3, OFF_CYCLES=2 and a
// combinational-read memory model driven by the registered address.
module tb_exibe_sequencia;

    logic       clock = 1'b0;
    logic       reset;
    logic       iniciar;
    logic [3:0] rodada;
    logic [3:0] dado;
    logic [3:0] endereco;
    logic [3:0] leds;
    logic       ocupado;
    logic       pronto;
    logic [3:0] db_estado;

    logic [3:0] mem [16];
    int total   = 0;
    int bad     = 0;
    int n_pronto = 0;

    exibe_sequencia #(
        .ON_CYCLES  (3),
        .OFF_CYCLES (2),
        .CNT_W      (13)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .iniciar   (iniciar),
        .rodada    (rodada),
        .dado      (dado),
        .endereco  (endereco),
        .leds      (leds),
        .ocupado   (ocupado),
        .pronto    (pronto),
        .db_estado (db_estado)
    );

    always #5 clock = ~clock;

    assign dado = mem[endereco];

    always @(negedge clock) if (pronto === 1'b1) n_pronto++;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic chk_all(input string ctx, input logic [3:0] e_est, input logic [3:0] e_end,
                           input logic [3:0] e_led, input logic e_oc, input logic e_pr);
        chk({ctx, ".estado"},   32'(db_estado), 32'(e_est));
        chk({ctx, ".endereco"}, 32'(endereco),  32'(e_end));
        chk({ctx, ".leds"},     32'(leds),      32'(e_led));
        chk({ctx, ".ocupado"},  32'(ocupado),   32'(e_oc));
        chk({ctx, ".pronto"},   32'(pronto),    32'(e_pr));
    endtask

    // Starts a run at edge 0 and checks every cycle through the idle cycle after FIM.
    task automatic run_seq(input string ctx, input logic [3:0] r, input int exp_pronto,
                           input int hold, input int chg_at, input logic [3:0] chg_val);
        int fim_c;
        int first;
        int k;
        int p;
        logic [3:0] e_est;
        logic [3:0] e_led;
        rodada  = r;
        iniciar = 1'b1;
        step();
        fim_c = (int'(r) + 1) * 7 + 1;
        first = -1;
        for (int c = 1; c <= fim_c + 1; c++) begin
            if (c == fim_c) begin
                chk_all(ctx, 4'd5, r, 4'd0, 1'b1, 1'b1);
            end else if (c == fim_c + 1) begin
                chk_all(ctx, 4'd0, r, 4'd0, 1'b0, 1'b0);
            end else begin
                k = (c - 1) / 7;
                p = (c - 1) % 7;
                e_led = (p >= 1 && p <= 3) ? mem[k] : 4'd0;
                e_est = (p == 0) ? 4'd1 : (p <= 3) ? 4'd2 : (p <= 5) ? 4'd3 : 4'd4;
                chk_all(ctx, e_est, 4'(k), e_led, 1'b1, 1'b0);
            end
            if (pronto === 1'b1 && first < 0) first = c;
            iniciar = (c < hold);
            if (c == chg_at) rodada = chg_val;
            step();
        end
        chk({ctx, ".ciclo_pronto"}, 32'(first), 32'(exp_pronto));
    endtask

    initial begin
        int np0;
        reset   = 1'b1;
        iniciar = 1'b0;
        rodada  = 4'd0;
        for (int i = 0; i < 16; i++) mem[i] = 4'd0;
        mem[0] = 4'b0001;
        mem[1] = 4'b0100;
        mem[2] = 4'b0010;
        mem[3] = 4'b1000;

        #12;
        chk_all("reset", 4'd0, 4'd0, 4'd0, 1'b0, 1'b0);
        reset = 1'b0;
        step();

        for (int i = 0; i < 20; i++) begin
            chk_all("ocioso", 4'd0, 4'd0, 4'd0, 1'b0, 1'b0);
            step();
        end

        run_seq("rodada1", 4'd1, 15, 1, 0, 4'd0);
        run_seq("rodada0", 4'd0, 8, 1, 0, 4'd0);
        run_seq("rodada3", 4'd3, 29, 1, 0, 4'd0);
        chk("rodada3.endereco_final", 32'(endereco), 32'd3);

        run_seq("segurado", 4'd1, 15, 10, 4, 4'd3);

        rodada  = 4'd1;
        iniciar = 1'b1;
        step();
        iniciar = 1'b0;
        for (int i = 0; i < 9; i++) step();
        chk("meio.leds_antes", 32'(leds), 32'(4'b0100));
        chk("meio.endereco_antes", 32'(endereco), 32'd1);
        np0 = n_pronto;
        reset = 1'b1;
        #1;
        chk_all("reset_meio", 4'd0, 4'd0, 4'd0, 1'b0, 1'b0);
        step();
        step();
        reset = 1'b0;
        for (int i = 0; i < 10; i++) step();
        chk("reset_meio.sem_pronto", 32'(n_pronto), 32'(np0));
        run_seq("reinicio", 4'd1, 15, 1, 0, 4'd0);
        chk("reinicio.um_pronto", 32'(n_pronto), 32'(np0 + 1));

        for (int i = 0; i < 16; i++) mem[i] = 4'(i);
        run_seq("rodada15", 4'd15, 113, 1, 0, 4'd0);
        chk("rodada15.endereco_final", 32'(endereco), 32'd15);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
